// File: rtl/jt7759_pkg.sv
// Shared jt7759 definitions: ROM address width and the ROM arbiter state encoding.
package jt7759_pkg;

  localparam int JT7759_AW = 17;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } arb_state_t;

endpackage

// File: rtl/jt7759_romcache.sv
// One-byte read cache for a single jt7759 requester: holds tag, data and valid bit.
module jt7759_romcache
  import jt7759_pkg::*;
#(
  parameter int AW = JT7759_AW
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          flush,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic [7:0]    fill_data,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  output logic [7:0]    data,
  output logic          ok
);

  logic [AW-1:0] tag;
  logic          vld;

  // A fill always leaves the entry valid, even when a flush arrives in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag  <= '0;
      data <= '0;
      vld  <= 1'b0;
    end else if (fill) begin
      tag  <= fill_addr;
      data <= fill_data;
      vld  <= 1'b1;
    end else if (flush) begin
      vld <= 1'b0;
    end
  end

  assign ok = cs & vld & (tag == addr);

endmodule

// File: rtl/jt7759_romarb.sv
// Two-requester ROM port arbiter for dual jt7759 boards: per-requester byte cache,
// round-robin miss arbitration, one memory access in flight at a time.
module jt7759_romarb
  import jt7759_pkg::*;
#(
  parameter int AW      = JT7759_AW,
  parameter int MINWAIT = 1
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          flush,
  input  logic          r0_cs,
  input  logic [AW-1:0] r0_addr,
  output logic [7:0]    r0_data,
  output logic          r0_ok,
  input  logic          r1_cs,
  input  logic [AW-1:0] r1_addr,
  output logic [7:0]    r1_data,
  output logic          r1_ok,
  output logic          mem_cs,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_data,
  input  logic          mem_ok
);

  // The counter reaching zero means mem_ok is honoured on the following edge,
  // i.e. MINWAIT cycles after mem_cs/mem_addr were presented.
  localparam logic [1:0] WAIT_LOAD = 2'(MINWAIT - 1);

  arb_state_t state;
  logic       ptr;
  logic       gnt;
  logic       tie;
  logic [1:0] cnt;
  logic       miss0;
  logic       miss1;
  logic       next_gnt;
  logic       fill;

  assign miss0    = r0_cs & ~r0_ok;
  assign miss1    = r1_cs & ~r1_ok;
  assign next_gnt = (miss0 & miss1) ? ptr : miss1;
  assign fill     = (state == WAIT) && (cnt == 2'd0) && mem_ok;

  jt7759_romcache #(.AW(AW)) u_cache0 (
    .rst       (rst),
    .clk       (clk),
    .flush     (flush),
    .fill      (fill & ~gnt),
    .fill_addr (mem_addr),
    .fill_data (mem_data),
    .cs        (r0_cs),
    .addr      (r0_addr),
    .data      (r0_data),
    .ok        (r0_ok)
  );

  jt7759_romcache #(.AW(AW)) u_cache1 (
    .rst       (rst),
    .clk       (clk),
    .flush     (flush),
    .fill      (fill & gnt),
    .fill_addr (mem_addr),
    .fill_data (mem_data),
    .cs        (r1_cs),
    .addr      (r1_addr),
    .data      (r1_data),
    .ok        (r1_ok)
  );

  // ptr names the winner of the next tie; it moves only after a contested access,
  // so the loser of a tie always gets the following one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mem_cs   <= 1'b0;
      mem_addr <= '0;
      ptr      <= 1'b0;
      gnt      <= 1'b0;
      tie      <= 1'b0;
      cnt      <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (miss0 | miss1) begin
            gnt      <= next_gnt;
            tie      <= miss0 & miss1;
            mem_addr <= next_gnt ? r1_addr : r0_addr;
            mem_cs   <= 1'b1;
            cnt      <= WAIT_LOAD;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else if (mem_ok) begin
            mem_cs <= 1'b0;
            if (tie) ptr <= ~gnt;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt7759_romarb.sv
// Self-checking bench for jt7759_romarb: transaction-timing model plus directed literal checks.
module tb_jt7759_romarb;

  localparam int AW      = 17;
  localparam int MINWAIT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          r0_cs, r1_cs;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [7:0]    r0_data, r1_data;
  logic          r0_ok, r1_ok;
  logic          mem_cs;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          mem_ok;

  logic          q0_cs;
  logic [AW-1:0] q0_addr;
  logic [7:0]    q0_data, q1_data;
  logic          q0_ok, q1_ok;
  logic          q_mem_cs;
  logic [AW-1:0] q_mem_addr;
  logic [7:0]    q_mem_data;
  logic          q1_cs = 1'b0;
  logic [AW-1:0] q1_addr = '0;
  logic          q_flush = 1'b0;
  logic          q_mem_ok = 1'b1;

  int nvec = 0;
  int nerr = 0;
  bit check_en = 0;
  bit mem_always;
  int lat;
  int age;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'hA5;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  jt7759_romarb #(.AW(AW), .MINWAIT(MINWAIT)) dut (
    .rst(rst), .clk(clk), .flush(flush),
    .r0_cs(r0_cs), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ok(r0_ok),
    .r1_cs(r1_cs), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ok(r1_ok),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ok(mem_ok)
  );

  jt7759_romarb #(.AW(AW), .MINWAIT(2)) dut2 (
    .rst(rst), .clk(clk), .flush(q_flush),
    .r0_cs(q0_cs), .r0_addr(q0_addr), .r0_data(q0_data), .r0_ok(q0_ok),
    .r1_cs(q1_cs), .r1_addr(q1_addr), .r1_data(q1_data), .r1_ok(q1_ok),
    .mem_cs(q_mem_cs), .mem_addr(q_mem_addr), .mem_data(q_mem_data), .mem_ok(q_mem_ok)
  );

  // Memory: data is a fixed function of the address; ok comes lat cycles after the strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) age <= 0;
    else     age <= mem_cs ? age + 1 : 0;
  end
  assign mem_ok     = mem_always ? 1'b1 : (mem_cs && (age >= lat - 1));
  assign mem_data   = rom_f(mem_addr);
  assign q_mem_data = rom_f(q_mem_addr);

  // Model: each cache as tag/data/valid; each access as a grant edge and a fill edge.
  bit            mvld [2];
  logic [AW-1:0] mtag [2];
  logic [7:0]    mdat [2];
  logic [AW-1:0] maddr;
  logic [AW-1:0] gaddr;
  bit            busy, next_tie, g, m0, m1;
  int            cyc, fill_at, free_at;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mvld[i] = 0; mtag[i] = '0; mdat[i] = 8'h00;
      end
      maddr = '0; gaddr = '0; busy = 0; next_tie = 0; g = 0;
      fill_at = 0; free_at = 0;
    end else begin
      cyc++;
      m0 = r0_cs && !(mvld[0] && mtag[0] == r0_addr);
      m1 = r1_cs && !(mvld[1] && mtag[1] == r1_addr);
      if (flush) begin
        mvld[0] = 0; mvld[1] = 0;
      end
      if (busy && cyc == fill_at) begin
        mtag[g] = gaddr; mdat[g] = rom_f(gaddr); mvld[g] = 1;
        busy = 0; free_at = cyc + 2;
      end else if (!busy && cyc >= free_at && (m0 || m1)) begin
        if (m0 && m1) begin
          g = next_tie; next_tie = !next_tie;
        end else begin
          g = m1;
        end
        gaddr = g ? r1_addr : r0_addr;
        maddr = gaddr;
        busy  = 1;
        fill_at = cyc + (mem_always ? MINWAIT : imax(MINWAIT, lat));
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check_output("r0_ok",    32'(r0_ok),    32'(r0_cs && mvld[0] && mtag[0] == r0_addr));
      check_output("r1_ok",    32'(r1_ok),    32'(r1_cs && mvld[1] && mtag[1] == r1_addr));
      check_output("r0_data",  32'(r0_data),  32'(mdat[0]));
      check_output("r1_data",  32'(r1_data),  32'(mdat[1]));
      check_output("mem_cs",   32'(mem_cs),   32'(busy));
      check_output("mem_addr", 32'(mem_addr), 32'(maddr));
    end
  end

  logic [AW-1:0] grants[$];
  logic          prev_cs = 1'b0;
  always @(negedge clk) begin
    if (mem_cs && !prev_cs) grants.push_back(mem_addr);
    prev_cs = mem_cs;
  end

  task automatic apply_stimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ok(input int which, input int budget);
    int k = 0;
    while (((which == 0) ? r0_ok : r1_ok) !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_output((which == 0) ? "wait_r0_ok" : "wait_r1_ok",
                 32'((which == 0) ? r0_ok : r1_ok), 32'd1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; r0_cs = 1'b0; r1_cs = 1'b0; r0_addr = '0; r1_addr = '0;
    q0_cs = 1'b0; q0_addr = '0; mem_always = 0; lat = 4;
    apply_stimulus(1);
    check_en = 1;
    @(negedge clk);
    check_output("rst_mem_cs",   32'(mem_cs),   32'd0);
    check_output("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_output("rst_r0_data",  32'(r0_data),  32'd0);
    check_output("rst_r1_ok",    32'(r1_ok),    32'd0);
    apply_stimulus(1);
    rst = 1'b0;
    apply_stimulus(2);

    // First miss, memory latency 4
    r0_cs = 1'b1; r0_addr = 17'h00000;
    @(negedge clk);
    check_output("t1_pre_mem_cs", 32'(mem_cs), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("t1_mem_cs_busy", 32'(mem_cs), 32'd1);
      check_output("t1_r0_ok_low",   32'(r0_ok),  32'd0);
    end
    @(negedge clk);
    check_output("t1_mem_cs_done", 32'(mem_cs),  32'd0);
    check_output("t1_r0_ok",       32'(r0_ok),   32'd1);
    check_output("t1_r0_data",     32'(r0_data), 32'hA5);
    apply_stimulus(1);
    r0_cs = 1'b0;
    apply_stimulus(1);
    r0_cs = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("t1_repeat_no_mem", 32'(mem_cs), 32'd0);
      check_output("t1_repeat_hit",    32'(r0_ok),  32'd1);
    end
    apply_stimulus(1);
    r0_cs = 1'b0;
    apply_stimulus(2);

    // Tie: r0 first, then r1; next tie goes to r1
    r0_cs = 1'b1; r0_addr = 17'h00010; r1_cs = 1'b1; r1_addr = 17'h10000;
    wait_ok(0, 40);
    check_output("t2_r1_waits", 32'(r1_ok), 32'd0);
    wait_ok(1, 40);
    check_output("t2_r0_data", 32'(r0_data), 32'hB5);
    check_output("t2_r1_data", 32'(r1_data), 32'hA4);
    apply_stimulus(2);
    r0_addr = 17'h00020; r1_addr = 17'h10020;
    @(negedge clk);
    @(negedge clk);
    check_output("t2_tie2_mem_cs",   32'(mem_cs),   32'd1);
    check_output("t2_tie2_mem_addr", 32'(mem_addr), 32'h10020);
    wait_ok(1, 40);
    wait_ok(0, 40);
    check_output("t2_tie2_r0_data", 32'(r0_data), 32'h85);
    apply_stimulus(1);
    r0_cs = 1'b0; r1_cs = 1'b0;
    apply_stimulus(3);

    // Address change during WAIT
    grants.delete();
    r0_cs = 1'b1; r0_addr = 17'h00100;
    apply_stimulus(2);
    r0_addr = 17'h00101;
    @(negedge clk);
    check_output("t3_r0_ok_low", 32'(r0_ok), 32'd0);
    wait_ok(0, 40);
    check_output("t3_r0_data",   32'(r0_data), 32'hA5);
    check_output("t3_n_grants",  32'(grants.size()), 32'd2);
    if (grants.size() == 2) begin
      check_output("t3_grant0", 32'(grants[0]), 32'h00100);
      check_output("t3_grant1", 32'(grants[1]), 32'h00101);
    end
    apply_stimulus(1);
    r0_addr = 17'h00102;
    @(negedge clk);
    check_output("t3_ok_drops", 32'(r0_ok), 32'd0);
    wait_ok(0, 40);
    apply_stimulus(1);
    r0_cs = 1'b0;
    apply_stimulus(3);

    // Flush with both caches valid
    r0_cs = 1'b1; r0_addr = 17'h00200; r1_cs = 1'b1; r1_addr = 17'h00300;
    wait_ok(0, 40);
    wait_ok(1, 40);
    apply_stimulus(2);
    flush = 1'b1;
    apply_stimulus(1);
    flush = 1'b0;
    @(negedge clk);
    check_output("t4_flush_r0", 32'(r0_ok), 32'd0);
    check_output("t4_flush_r1", 32'(r1_ok), 32'd0);
    wait_ok(0, 40);
    wait_ok(1, 40);
    apply_stimulus(2);

    // Flush during WAIT: r0's in-flight fill survives, r1 refetches
    r0_addr = 17'h00400;
    apply_stimulus(2);
    flush = 1'b1;
    apply_stimulus(1);
    flush = 1'b0;
    wait_ok(0, 40);
    wait_ok(1, 40);
    apply_stimulus(2);

    // Flush coinciding with the fill edge
    r0_addr = 17'h00500;
    apply_stimulus(4);
    flush = 1'b1;
    apply_stimulus(1);
    flush = 1'b0;
    @(negedge clk);
    check_output("t6_fill_wins", 32'(r0_ok),   32'd1);
    check_output("t6_fill_data", 32'(r0_data), 32'hA0);
    check_output("t6_other_clr", 32'(r1_ok),   32'd0);
    wait_ok(1, 40);
    apply_stimulus(1);
    r0_cs = 1'b0; r1_cs = 1'b0;
    apply_stimulus(3);

    // mem_ok held high all the time
    mem_always = 1;
    apply_stimulus(2);
    r0_cs = 1'b1; r0_addr = 17'h00600;
    wait_ok(0, 10);
    check_output("t7_r0_data", 32'(r0_data), 32'hA3);
    apply_stimulus(4);
    r0_cs = 1'b0;
    apply_stimulus(2);
    mem_always = 0;

    // MINWAIT=2 instance with mem_ok permanently high
    q0_cs = 1'b1; q0_addr = 17'h00055;
    @(negedge clk);
    check_output("q_pre_mem_cs", 32'(q_mem_cs), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_output("q_window_cs", 32'(q_mem_cs), 32'd1);
      check_output("q_window_ok", 32'(q0_ok),    32'd0);
    end
    @(negedge clk);
    check_output("q_fill_cs",   32'(q_mem_cs), 32'd0);
    check_output("q_fill_ok",   32'(q0_ok),    32'd1);
    check_output("q_fill_data", 32'(q0_data),  32'hF0);
    apply_stimulus(1);
    q0_cs = 1'b0;
    apply_stimulus(2);

    // Reset mid-access, then the first tie goes to r0
    r1_cs = 1'b1; r1_addr = 17'h10700;
    wait_ok(1, 40);
    apply_stimulus(2);
    r0_cs = 1'b1; r0_addr = 17'h00800;
    apply_stimulus(2);
    check_output("t8_pre_r1_ok",  32'(r1_ok),  32'd1);
    check_output("t8_pre_mem_cs", 32'(mem_cs), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_output("t8_rst_mem_cs", 32'(mem_cs), 32'd0);
    check_output("t8_rst_r0_ok",  32'(r0_ok),  32'd0);
    check_output("t8_rst_r1_ok",  32'(r1_ok),  32'd0);
    apply_stimulus(2);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("t8_tie_mem_cs",   32'(mem_cs),   32'd1);
    check_output("t8_tie_mem_addr", 32'(mem_addr), 32'h00800);
    wait_ok(0, 40);
    wait_ok(1, 40);
    apply_stimulus(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
